team_06_clip_scheduler: RTL and testbench

- Sequences the shared combinational soft-clipping unit (team_06_soft_clipping) between two audio channels, ch0 and ch1.
- Each channel offers 8-bit samples over a valid/ready handshake. The block arbitrates round-robin, drives the clipper input and enable, registers the clipper result and presents it downstream over a valid/ready handshake.
- Applies the requested clip enable only at sample boundaries, so no sample is processed with a mid-flight enable change.
- Keeps a saturating count of samples that the clipper actually altered.

---
 rtl/team_06_clip_scheduler.sv | 137 +++++++++++++
 tb/tb_team_06_clip_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/team_06_clip_scheduler.sv
// Round-robin scheduler sharing one combinational soft-clipper between two
// audio channels, with a registered output stage and a saturating clip-event counter.
module team_06_clip_scheduler #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ch0_valid,
   input  logic [WIDTH-1:0] ch0_sample,
   output logic             ch0_ready,
   input  logic             ch1_valid,
   input  logic [WIDTH-1:0] ch1_sample,
   output logic             ch1_ready,
   input  logic             clip_en_req,
   output logic [WIDTH-1:0] clip_in,
   output logic             clip_en,
   input  logic [WIDTH-1:0] clip_result,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_sample,
   output logic             out_ch,
   input  logic             out_ready,
   input  logic             clr_count,
   output logic [CNT_W-1:0] clip_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLIP = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic             rr_ptr_reg, rr_ptr_next;
   logic [WIDTH-1:0] clip_in_reg, clip_in_next;
   logic             clip_en_reg, clip_en_next;
   logic             out_valid_reg, out_valid_next;
   logic [WIDTH-1:0] out_sample_reg, out_sample_next;
   logic             out_ch_reg, out_ch_next;
   logic [CNT_W-1:0] count_reg, count_next;

   logic             grant;
   logic             take;
   logic [WIDTH-1:0] grant_sample;
   logic             altered;

   // A lone requester always wins; contention is settled by the round-robin pointer.
   always_comb begin
      grant = rr_ptr_reg;
      if (ch0_valid && !ch1_valid) begin
         grant = 1'b0;
      end else if (ch1_valid && !ch0_valid) begin
         grant = 1'b1;
      end
   end

   assign ch0_ready    = (state_reg == IDLE) && !rst && !grant;
   assign ch1_ready    = (state_reg == IDLE) && !rst && grant;
   assign take         = (ch0_valid && ch0_ready) || (ch1_valid && ch1_ready);
   assign grant_sample = grant ? ch1_sample : ch0_sample;
   assign altered      = clip_en_reg && (clip_result != clip_in_reg);

   always_comb begin
      state_next      = state_reg;
      rr_ptr_next     = rr_ptr_reg;
      clip_in_next    = clip_in_reg;
      clip_en_next    = clip_en_reg;
      out_valid_next  = out_valid_reg;
      out_sample_next = out_sample_reg;
      out_ch_next     = out_ch_reg;
      count_next      = count_reg;

      case (state_reg)
         IDLE: begin
            // Enable is latched only here, so an in-flight sample never sees it change.
            if (take) begin
               clip_in_next = grant_sample;
               clip_en_next = clip_en_req;
               out_ch_next  = grant;
               state_next   = CLIP;
            end
         end
         CLIP: begin
            out_sample_next = clip_result;
            out_valid_next  = 1'b1;
            state_next      = OUT;
            if (altered && (count_reg != {CNT_W{1'b1}})) begin
               count_next = count_reg + 1'b1;
            end
         end
         OUT: begin
            if (out_ready) begin
               out_valid_next = 1'b0;
               rr_ptr_next    = ~out_ch_reg;
               state_next     = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (clr_count) begin
         count_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         rr_ptr_reg     <= 1'b0;
         clip_in_reg    <= '0;
         clip_en_reg    <= 1'b0;
         out_valid_reg  <= 1'b0;
         out_sample_reg <= '0;
         out_ch_reg     <= 1'b0;
         count_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         rr_ptr_reg     <= rr_ptr_next;
         clip_in_reg    <= clip_in_next;
         clip_en_reg    <= clip_en_next;
         out_valid_reg  <= out_valid_next;
         out_sample_reg <= out_sample_next;
         out_ch_reg     <= out_ch_next;
         count_reg      <= count_next;
      end
   end

   assign clip_in    = clip_in_reg;
   assign clip_en    = clip_en_reg;
   assign out_valid  = out_valid_reg;
   assign out_sample = out_sample_reg;
   assign out_ch     = out_ch_reg;
   assign clip_count = count_reg;

endmodule

// File: tb/tb_team_06_clip_scheduler.sv
// Directed bench for team_06_clip_scheduler with a min(x,200) clipper stub; a second
// narrow-counter instance shares all stimulus so counter saturation is reachable quickly.
module tb_team_06_clip_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ch0_valid = 1'b0;
   logic [7:0] ch0_sample = 8'd0;
   logic       ch1_valid = 1'b0;
   logic [7:0] ch1_sample = 8'd0;
   logic       clip_en_req = 1'b0;
   logic       out_ready = 1'b1;
   logic       clr_count = 1'b0;

   logic        ch0_ready, ch1_ready;
   logic [7:0]  clip_in, clip_result, out_sample;
   logic        clip_en, out_valid, out_ch;
   logic [15:0] clip_count;

   logic       s_ch0_ready, s_ch1_ready;
   logic [7:0] s_clip_in, s_clip_result, s_out_sample;
   logic       s_clip_en, s_out_valid, s_out_ch;
   logic [1:0] s_clip_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign clip_result   = (clip_en && clip_in > 8'd200) ? 8'd200 : clip_in;
   assign s_clip_result = (s_clip_en && s_clip_in > 8'd200) ? 8'd200 : s_clip_in;

   team_06_clip_scheduler #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .ch0_valid(ch0_valid), .ch0_sample(ch0_sample), .ch0_ready(ch0_ready),
      .ch1_valid(ch1_valid), .ch1_sample(ch1_sample), .ch1_ready(ch1_ready),
      .clip_en_req(clip_en_req), .clip_in(clip_in), .clip_en(clip_en),
      .clip_result(clip_result), .out_valid(out_valid), .out_sample(out_sample),
      .out_ch(out_ch), .out_ready(out_ready), .clr_count(clr_count),
      .clip_count(clip_count)
   );

   team_06_clip_scheduler #(.WIDTH(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst),
      .ch0_valid(ch0_valid), .ch0_sample(ch0_sample), .ch0_ready(s_ch0_ready),
      .ch1_valid(ch1_valid), .ch1_sample(ch1_sample), .ch1_ready(s_ch1_ready),
      .clip_en_req(clip_en_req), .clip_in(s_clip_in), .clip_en(s_clip_en),
      .clip_result(s_clip_result), .out_valid(s_out_valid), .out_sample(s_out_sample),
      .out_ch(s_out_ch), .out_ready(out_ready), .clr_count(clr_count),
      .clip_count(s_clip_count)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One sample through the pipeline with out_ready high; en_after and clr_at_clip are
   // applied during the CLIP cycle.
   task automatic send(input bit ch, input logic [7:0] smp, input bit en_req, input bit en_after,
                       input bit clr_at_clip, input logic [7:0] exp_out, input int exp_count,
                       input string name);
      bit got = 1'b0;
      clip_en_req = en_req;
      if (ch) begin ch1_valid = 1'b1; ch1_sample = smp; end
      else    begin ch0_valid = 1'b1; ch0_sample = smp; end
      for (int i = 0; i < 10; i++) begin
         #1;
         if ((ch ? ch1_ready : ch0_ready) === 1'b1) begin got = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s ready_timeout: no ready within 10 cycles, required ready=1", name);
         ch0_valid = 1'b0; ch1_valid = 1'b0;
         return;
      end
      @(negedge clk);
      ch0_valid = 1'b0; ch1_valid = 1'b0;
      clip_en_req = en_after;
      clr_count = clr_at_clip;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL %s latency_early: out_valid=%b required 0", name, out_valid);
      end
      checks++;
      if (clip_in !== smp || clip_en !== en_req) begin
         errors++;
         $display("FAIL %s clip_drive: clip_in=%0d clip_en=%b required %0d %b", name, clip_in, clip_en, smp, en_req);
      end
      @(negedge clk);
      clr_count = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_sample !== exp_out || out_ch !== ch) begin
         errors++;
         $display("FAIL %s output: valid=%b sample=%0d ch=%b required 1 %0d %b", name, out_valid, out_sample, out_ch, exp_out, ch);
      end
      checks++;
      if (clip_count !== exp_count[15:0]) begin
         errors++; $display("FAIL %s clip_count: got %0d required %0d", name, clip_count, exp_count);
      end
      $display("txn %s ch=%0d in=%0d out=%0d count=%0d", name, ch, smp, out_sample, clip_count);
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL %s drain: out_valid=%b required 0", name, out_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; ch0_valid = 1'b1; ch1_valid = 1'b1;
      ch0_sample = 8'd33; ch1_sample = 8'd44;
      repeat (2) begin
         @(negedge clk);
         #1;
         checks++;
         if (ch0_ready !== 1'b0 || ch1_ready !== 1'b0 || out_valid !== 1'b0 || clip_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: rdy0=%b rdy1=%b out_valid=%b count=%0d required 0 0 0 0", ch0_ready, ch1_ready, out_valid, clip_count);
         end
      end
      checks++;
      if (clip_in !== 8'd0 || clip_en !== 1'b0 || out_sample !== 8'd0 || out_ch !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs: clip_in=%0d clip_en=%b out_sample=%0d out_ch=%b required zeros", clip_in, clip_en, out_sample, out_ch);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (ch0_ready !== 1'b1 || ch1_ready !== 1'b0) begin
         errors++; $display("FAIL reset_first_grant: rdy0=%b rdy1=%b required 1 0", ch0_ready, ch1_ready);
      end
      ch0_valid = 1'b0; ch1_valid = 1'b0;
      $display("txn reset released");
      @(negedge clk);
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      send(1'b0, 8'd20,  1'b1, 1'b1, 1'b0, 8'd20,  0, "single_20");
      send(1'b0, 8'd110, 1'b1, 1'b1, 1'b0, 8'd110, 0, "single_110");
      send(1'b0, 8'd255, 1'b1, 1'b1, 1'b0, 8'd200, 1, "single_255");
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_s [4] = '{8'd60, 8'd200, 8'd60, 8'd200};
      bit         exp_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      int         exp_n [4] = '{0, 1, 1, 2};
      int got = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clip_en_req = 1'b1; out_ready = 1'b1;
      ch0_valid = 1'b1; ch0_sample = 8'd60;
      ch1_valid = 1'b1; ch1_sample = 8'd220;
      for (int i = 0; i < 30 && got < 4; i++) begin
         #1;
         checks++;
         if (ch0_ready === 1'b1 && ch1_ready === 1'b1) begin
            errors++; $display("FAIL rr_one_ready: both readies high, required at most one");
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (out_ch !== exp_c[got] || out_sample !== exp_s[got] || clip_count !== exp_n[got][15:0]) begin
               errors++;
               $display("FAIL rr_out%0d: ch=%b sample=%0d count=%0d required %b %0d %0d", got, out_ch, out_sample, clip_count, exp_c[got], exp_s[got], exp_n[got]);
            end
            $display("txn rr ch=%0d out=%0d count=%0d", out_ch, out_sample, clip_count);
            got++;
            if (got == 4) begin ch0_valid = 1'b0; ch1_valid = 1'b0; end
         end
         @(negedge clk);
      end
      checks++;
      if (got != 4) begin
         errors++; $display("FAIL rr_count_outputs: got %0d outputs required 4", got);
      end
      #1;
      checks++;
      if (out_valid !== 1'b0 || clip_count !== 16'd2) begin
         errors++; $display("FAIL rr_end: out_valid=%b count=%0d required 0 2", out_valid, clip_count);
      end
   endtask

   task automatic test_enable_boundary();
      send(1'b0, 8'd255, 1'b1, 1'b0, 1'b0, 8'd200, 3, "en_drop_midflight");
      send(1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 8'd255, 3, "en_off");
   endtask

   task automatic test_backpressure();
      int transfers = 0;
      bit got = 1'b0;
      out_ready = 1'b0; clip_en_req = 1'b1;
      ch1_valid = 1'b1; ch1_sample = 8'd150;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (ch1_ready === 1'b1) begin got = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!got) begin
         errors++; $display("FAIL bp_ready_timeout: ch1_ready never 1, required 1");
      end
      @(negedge clk);
      ch1_valid = 1'b0;
      ch0_valid = 1'b1; ch0_sample = 8'd5;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_sample !== 8'd150 || out_ch !== 1'b1 || ch0_ready !== 1'b0 || ch1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b sample=%0d ch=%b rdy0=%b rdy1=%b required 1 150 1 0 0", i, out_valid, out_sample, out_ch, ch0_ready, ch1_ready);
         end
         @(negedge clk);
      end
      out_ready = 1'b1; ch0_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (out_valid === 1'b1 && out_ready === 1'b1) transfers++;
         @(negedge clk);
      end
      checks++;
      if (transfers != 1) begin
         errors++; $display("FAIL bp_transfers: got %0d required 1", transfers);
      end
      checks++;
      if (clip_count !== 16'd3) begin
         errors++; $display("FAIL bp_count: got %0d required 3", clip_count);
      end
      $display("txn backpressure ch=1 out=150 transfers=%0d", transfers);
   endtask

   task automatic test_counter_edges();
      bit got = 1'b0;
      send(1'b0, 8'd255, 1'b1, 1'b1, 1'b0, 8'd200, 4, "cnt_inc4");
      checks++;
      if (s_clip_count !== 2'd3) begin
         errors++; $display("FAIL sat_hold_a: narrow count=%0d required 3", s_clip_count);
      end
      send(1'b0, 8'd255, 1'b1, 1'b1, 1'b0, 8'd200, 5, "cnt_inc5");
      checks++;
      if (s_clip_count !== 2'd3) begin
         errors++; $display("FAIL sat_hold_b: narrow count=%0d required 3", s_clip_count);
      end
      send(1'b0, 8'd255, 1'b1, 1'b1, 1'b1, 8'd200, 0, "cnt_clr_vs_inc");
      checks++;
      if (s_clip_count !== 2'd0) begin
         errors++; $display("FAIL clr_narrow: narrow count=%0d required 0", s_clip_count);
      end
      // Reset while the sample sits in CLIP: it must vanish.
      clip_en_req = 1'b1;
      ch0_valid = 1'b1; ch0_sample = 8'd255;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (ch0_ready === 1'b1) begin got = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!got) begin
         errors++; $display("FAIL rst_mid_ready_timeout: ch0_ready never 1, required 1");
      end
      @(negedge clk);
      ch0_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || clip_count !== 16'd0 || clip_in !== 8'd0) begin
         errors++;
         $display("FAIL rst_mid_clip: out_valid=%b count=%0d clip_in=%0d required 0 0 0", out_valid, clip_count, clip_in);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (ch0_ready !== 1'b1 || ch1_ready !== 1'b0) begin
         errors++; $display("FAIL rst_mid_rr_restart: rdy0=%b rdy1=%b required 1 0", ch0_ready, ch1_ready);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_no_output%0d: out_valid=%b required 0", i, out_valid);
         end
      end
      $display("txn reset_mid_clip discarded");
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_enable_boundary();
      test_backpressure();
      test_counter_edges();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
